axi_xbar_1to3: RTL
==================

# axi_xbar_1to3

AXI4-Lite 1-master-to-3-slave address router. It sits between the CPU-side arbiter output and the memory/peripheral slaves (SRAM, UART, CLINT). Each read and write transaction goes to exactly one slave, selected by address. Transactions that hit no region are completed internally with a DECERR response, so the master never hangs.

## Interface
- `S0_BASE`, default 32'h8000_0000: SRAM region base.
- `S0_MASK`, default 32'hF800_0000: SRAM region mask. A hit is `(addr & MASK) == BASE`.
- `S1_BASE`, default 32'h1000_0000: UART region base.
- `S1_MASK`, default 32'hFFFF_F000: UART region mask.
- `S2_BASE`, default 32'h0200_0000: CLINT region base.
- `S2_MASK`, default 32'hFFFF_0000: CLINT region mask.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `m`, axi_lite_if.slave, bundle: upstream master port. Signals: araddr[31:0], wdata[31:0], wmask[3:0], rresp/bresp[1:0].
- `s0`, axi_lite_if.master, bundle: SRAM port.
- `s1`, axi_lite_if.master, bundle: UART port.
- `s2`, axi_lite_if.master, bundle: CLINT port.

## Operation
- Decode priority is s0 > s1 > s2 when regions overlap. No hit selects target ERR.
- The read and write paths are independent. One read and one write may be outstanding at the same time, possibly to different slaves.
- Read FSM states: RD_IDLE, RD_BUSY, RD_ERR.
  - RD_IDLE: `m.arvalid`/`araddr` are forwarded combinationally to the decoded slave only. `m.arready` = that slave's `arready`.
  - RD_IDLE on an AR handshake to slave k: latch `rsel`=k, go to RD_BUSY.
  - RD_IDLE on ERR: `m.arready`=1; go to RD_ERR on handshake.
  - RD_BUSY: R channel of `s[rsel]` is routed to `m`. The other slaves see `rready`=0. Return to RD_IDLE on `rvalid && rready`.
  - RD_ERR: `m.rvalid`=1, `rresp`=2'b11, `rdata`=0. Return to RD_IDLE on `m.rready`.
  - `m.arready`=0 in every state except RD_IDLE.
- Write FSM states: WR_IDLE, WR_W, WR_B, WR_ERR_W, WR_ERR_B.
  - WR_IDLE: AW is forwarded to the decoded slave. W is forwarded to the same slave only while `m.awvalid`=1. A W presented without AW is stalled (`wready`=0).
  - AW handshake with the W handshake in the same cycle: go to WR_B. AW handshake alone: go to WR_W. `wsel` is latched on the AW handshake.
  - WR_W: W is routed to `s[wsel]`. Go to WR_B on the W handshake.
  - WR_B: B is routed from `s[wsel]`. Go to WR_IDLE on `bvalid && bready`.
  - ERR target: the internal responder accepts AW and W with ready=1. It moves through WR_ERR_W if W is still pending, then to WR_ERR_B. In WR_ERR_B: `bvalid`=1, `bresp`=2'b11.
- Signals not selected: `valid`/`ready` driven 0, data driven from `m` (don't-care).

## Timing
- Reset: both FSMs go to IDLE. While `reset`=1, every valid and ready output on all four ports is forced to 0.
- Routed traffic adds zero cycles: AR/AW/W/R/B pass through combinationally in the cycle they are presented.
- Decode error: AR is accepted in cycle t, `m.rvalid` rises in t+1. Write with AW+W in cycle t: `m.bvalid` rises in t+1.
- Back-to-back reads: a new AR can be accepted in the cycle after the R handshake. R-handshake-to-next-AR bubble is ≥1 cycle.
- The address mux selects only on the master-side `araddr`/`awaddr`. `valid` must not depend on `ready`.
- Reset asserted mid-transaction: state is dropped, with no response owed. Slaves are reset by the same `reset`.
- Simultaneous AR and AW to the same slave: both are forwarded. Ordering between them is the slave's responsibility.

## Structure
- Shared package `axi_pkg`:
  - `resp_t` constants OKAY=2'b00, DECERR=2'b11.
  - `tgt_t` enum {TGT_S0, TGT_S1, TGT_S2, TGT_ERR}.
  - Region base/mask defaults.
- Sub-module `axi_addr_decode`: combinational, maps addr → `tgt_t`. It is instantiated twice, once for AR and once for AW.
- FSMs and muxes live in the top module. Target estimate is ~250 lines.

## Test plan
- Read 0x8000_0010 with the SRAM returning 0xDEAD_BEEF after 3 cycles → `m.rdata`=0xDEAD_BEEF, `rresp`=0. `s1`/`s2` `arvalid` stay 0 throughout.
- Write 0x1000_0000 with AW+W in the same cycle, UART `bvalid` after 2 cycles → WR_IDLE→WR_B→WR_IDLE. `m.bresp`=0.
- AW to 0x0200_4000 in cycle 0, W in cycle 2 → CLINT sees `wvalid` only in cycle 2. `m.wready`=0 for any W presented before the AW.
- Read 0x0000_0000 (unmapped) → `arready`=1 at t, `rvalid`=1 at t+1 with `rresp`=2'b11 and `rdata`=0. `rvalid` is held 2 extra cycles while `rready`=0.
- Concurrent traffic: a UART write outstanding while an SRAM read is issued → both complete independently. No R/B crossover between ports.
- Reset asserted while in RD_BUSY → all valids/readies are 0 during reset. Next cycle is RD_IDLE, and a new read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types for the AXI4-Lite crossbar: responses, decode targets,
// region defaults and FSM state encodings.
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t DECERR = 2'b11;

    typedef enum logic [1:0] {
        TGT_S0,
        TGT_S1,
        TGT_S2,
        TGT_ERR
    } tgt_t;

    localparam logic [31:0] S0_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] S0_MASK_DEF = 32'hF800_0000;
    localparam logic [31:0] S1_BASE_DEF = 32'h1000_0000;
    localparam logic [31:0] S1_MASK_DEF = 32'hFFFF_F000;
    localparam logic [31:0] S2_BASE_DEF = 32'h0200_0000;
    localparam logic [31:0] S2_MASK_DEF = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BUSY,
        RD_ERR
    } rd_state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_W,
        WR_B,
        WR_ERR_W,
        WR_ERR_B
    } wr_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with master/slave views.
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_addr_decode.sv
// Address-to-target decoder; lower slave index wins on overlapping regions.
module axi_addr_decode
    import axi_pkg::*;
#(
    parameter logic [31:0] S0_BASE = S0_BASE_DEF,
    parameter logic [31:0] S0_MASK = S0_MASK_DEF,
    parameter logic [31:0] S1_BASE = S1_BASE_DEF,
    parameter logic [31:0] S1_MASK = S1_MASK_DEF,
    parameter logic [31:0] S2_BASE = S2_BASE_DEF,
    parameter logic [31:0] S2_MASK = S2_MASK_DEF
) (
    input  logic [31:0] addr,
    output tgt_t        tgt
);
    always_comb begin
        if ((addr & S0_MASK) == S0_BASE)
            tgt = TGT_S0;
        else if ((addr & S1_MASK) == S1_BASE)
            tgt = TGT_S1;
        else if ((addr & S2_MASK) == S2_BASE)
            tgt = TGT_S2;
        else
            tgt = TGT_ERR;
    end
endmodule

// File: rtl/axi_xbar_1to3.sv
// AXI4-Lite 1-to-3 router with independent read/write FSMs and an
// internal DECERR responder for unmapped addresses.
module axi_xbar_1to3
    import axi_pkg::*;
#(
    parameter logic [31:0] S0_BASE = S0_BASE_DEF,
    parameter logic [31:0] S0_MASK = S0_MASK_DEF,
    parameter logic [31:0] S1_BASE = S1_BASE_DEF,
    parameter logic [31:0] S1_MASK = S1_MASK_DEF,
    parameter logic [31:0] S2_BASE = S2_BASE_DEF,
    parameter logic [31:0] S2_MASK = S2_MASK_DEF
) (
    input logic       clk,
    input logic       reset,
    axi_lite_if.slave  m,
    axi_lite_if.master s0,
    axi_lite_if.master s1,
    axi_lite_if.master s2
);
    tgt_t      ar_tgt, aw_tgt, rsel, wsel;
    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    // Slot 3 stands for the internal error responder.
    logic [3:0]  arready_v, awready_v, wready_v, rvalid_v, bvalid_v;
    logic [31:0] rdata_v [4];
    resp_t       rresp_v [4];
    resp_t       bresp_v [4];

    logic [2:0]  arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
    logic        ar_ready, r_valid, aw_ready, w_ready, b_valid;
    logic [31:0] r_data;
    resp_t       r_resp, b_resp;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

    axi_addr_decode #(
        .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
        .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
        .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
    ) u_ar_dec (.addr(m.araddr), .tgt(ar_tgt));

    axi_addr_decode #(
        .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
        .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
        .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
    ) u_aw_dec (.addr(m.awaddr), .tgt(aw_tgt));

    assign arready_v = {1'b1, s2.arready, s1.arready, s0.arready};
    assign awready_v = {1'b1, s2.awready, s1.awready, s0.awready};
    assign wready_v  = {1'b1, s2.wready, s1.wready, s0.wready};
    assign rvalid_v  = {1'b0, s2.rvalid, s1.rvalid, s0.rvalid};
    assign bvalid_v  = {1'b0, s2.bvalid, s1.bvalid, s0.bvalid};
    assign rdata_v   = '{s0.rdata, s1.rdata, s2.rdata, 32'h0};
    assign rresp_v   = '{s0.rresp, s1.rresp, s2.rresp, DECERR};
    assign bresp_v   = '{s0.bresp, s1.bresp, s2.bresp, DECERR};

    assign ar_hs = m.arvalid && ar_ready;
    assign r_hs  = r_valid && m.rready;
    assign aw_hs = m.awvalid && aw_ready;
    assign w_hs  = m.wvalid && w_ready;
    assign b_hs  = b_valid && m.bready;

    // ---------------- read path ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rsel     <= TGT_S0;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && ar_hs)
                rsel <= ar_tgt;
        end
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = (ar_tgt == TGT_ERR) ? RD_ERR : RD_BUSY;
            RD_BUSY: if (r_hs) rd_next = RD_IDLE;
            RD_ERR:  if (m.rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        arvalid_o = '0;
        rready_o  = '0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_data    = 32'h0;
        r_resp    = OKAY;
        if (!reset) begin
            unique case (rd_state)
                RD_IDLE: begin
                    ar_ready = arready_v[ar_tgt];
                    for (int i = 0; i < 3; i++)
                        arvalid_o[i] = m.arvalid && (ar_tgt == tgt_t'(2'(i)));
                end
                RD_BUSY: begin
                    r_valid = rvalid_v[rsel];
                    r_data  = rdata_v[rsel];
                    r_resp  = rresp_v[rsel];
                    for (int i = 0; i < 3; i++)
                        rready_o[i] = m.rready && (rsel == tgt_t'(2'(i)));
                end
                RD_ERR: begin
                    r_valid = 1'b1;
                    r_resp  = DECERR;
                end
                default: ;
            endcase
        end
    end

    // ---------------- write path ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            wsel     <= TGT_S0;
        end else begin
            wr_state <= wr_next;
            if (wr_state == WR_IDLE && aw_hs)
                wsel <= aw_tgt;
        end
    end

    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            WR_IDLE: begin
                if (aw_hs) begin
                    if (aw_tgt == TGT_ERR)
                        wr_next = w_hs ? WR_ERR_B : WR_ERR_W;
                    else
                        wr_next = w_hs ? WR_B : WR_W;
                end
            end
            WR_W:     if (w_hs) wr_next = WR_B;
            WR_B:     if (b_hs) wr_next = WR_IDLE;
            WR_ERR_W: if (m.wvalid) wr_next = WR_ERR_B;
            WR_ERR_B: if (m.bready) wr_next = WR_IDLE;
            default:  wr_next = WR_IDLE;
        endcase
    end

    // W is only forwarded alongside AW while idle, so a lone W stalls.
    always_comb begin
        awvalid_o = '0;
        wvalid_o  = '0;
        bready_o  = '0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_resp    = OKAY;
        if (!reset) begin
            unique case (wr_state)
                WR_IDLE: begin
                    aw_ready = awready_v[aw_tgt];
                    w_ready  = m.awvalid && wready_v[aw_tgt];
                    for (int i = 0; i < 3; i++) begin
                        awvalid_o[i] = m.awvalid && (aw_tgt == tgt_t'(2'(i)));
                        wvalid_o[i]  = m.awvalid && m.wvalid
                                       && (aw_tgt == tgt_t'(2'(i)));
                    end
                end
                WR_W: begin
                    w_ready = wready_v[wsel];
                    for (int i = 0; i < 3; i++)
                        wvalid_o[i] = m.wvalid && (wsel == tgt_t'(2'(i)));
                end
                WR_B: begin
                    b_valid = bvalid_v[wsel];
                    b_resp  = bresp_v[wsel];
                    for (int i = 0; i < 3; i++)
                        bready_o[i] = m.bready && (wsel == tgt_t'(2'(i)));
                end
                WR_ERR_W: w_ready = 1'b1;
                WR_ERR_B: begin
                    b_valid = 1'b1;
                    b_resp  = DECERR;
                end
                default: ;
            endcase
        end
    end

    assign m.arready = ar_ready;
    assign m.rvalid  = r_valid;
    assign m.rdata   = r_data;
    assign m.rresp   = r_resp;
    assign m.awready = aw_ready;
    assign m.wready  = w_ready;
    assign m.bvalid  = b_valid;
    assign m.bresp   = b_resp;

    assign s0.araddr  = m.araddr;
    assign s0.arvalid = arvalid_o[0];
    assign s0.rready  = rready_o[0];
    assign s0.awaddr  = m.awaddr;
    assign s0.awvalid = awvalid_o[0];
    assign s0.wdata   = m.wdata;
    assign s0.wmask   = m.wmask;
    assign s0.wvalid  = wvalid_o[0];
    assign s0.bready  = bready_o[0];

    assign s1.araddr  = m.araddr;
    assign s1.arvalid = arvalid_o[1];
    assign s1.rready  = rready_o[1];
    assign s1.awaddr  = m.awaddr;
    assign s1.awvalid = awvalid_o[1];
    assign s1.wdata   = m.wdata;
    assign s1.wmask   = m.wmask;
    assign s1.wvalid  = wvalid_o[1];
    assign s1.bready  = bready_o[1];

    assign s2.araddr  = m.araddr;
    assign s2.arvalid = arvalid_o[2];
    assign s2.rready  = rready_o[2];
    assign s2.awaddr  = m.awaddr;
    assign s2.awvalid = awvalid_o[2];
    assign s2.wdata   = m.wdata;
    assign s2.wmask   = m.wmask;
    assign s2.wvalid  = wvalid_o[2];
    assign s2.bready  = bready_o[2];

endmodule
